// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter: FSM state encoding, lane id type
// and the round-robin pointer advance used after a non-priority grant.
package uart_arb_pkg;

    localparam int MAX_REQ = 4;

    typedef logic [1:0] lane_id_t;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOAD,
        GUARD,
        DRAIN
    } arb_state_t;

    // Lane after cur, skipping the priority lane (it never sits in the rotation).
    function automatic lane_id_t next_lane(lane_id_t cur, int num_req, int prio);
        int n;
        n = (int'(cur) + 1) % num_req;
        if (n == prio) begin
            n = (n + 1) % num_req;
        end
        return lane_id_t'(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational search for the first valid non-priority lane at or after the rr pointer.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int PRIO_LANE = 0
) (
    input  logic [NUM_REQ-1:0] valid,
    input  lane_id_t           rr,
    output logic               found,
    output lane_id_t           pick
);

    always_comb begin
        found = 1'b0;
        pick  = rr;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && k != PRIO_LANE && k == (int'(rr) + i) % NUM_REQ && valid[k]) begin
                    found = 1'b1;
                    pick  = lane_id_t'(k);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one uart_tx between NUM_REQ byte-stream lanes, with a
// priority lane, starvation guard, requester-stall timeout and tx_ready byte pacing.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int PRIO_LANE    = 0,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][7:0] req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [7:0]              data_tx,
    output logic                    valid,
    input  logic                    tx_ready,
    output lane_id_t                grant_id,
    output logic                    busy,
    output logic                    msg_abort
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] PRIO_MASK = NUM_REQ'(1) << PRIO_LANE;
    localparam lane_id_t RR_INIT = lane_id_t'((PRIO_LANE + 1) % NUM_REQ);

    arb_state_t     state, state_next;
    lane_id_t       rr, pick, arb_grant;
    logic           pick_found, other_valid, prio_win, grant_ok;
    logic [7:0]     starve_cnt;
    logic [TW-1:0]  to_cnt;
    logic           last_q;
    logic           g_valid, g_last;
    logic [7:0]     g_data;
    logic           accept, stall, expire;

    rr_picker #(.NUM_REQ(NUM_REQ), .PRIO_LANE(PRIO_LANE)) u_pick (
        .valid (req_valid),
        .rr    (rr),
        .found (pick_found),
        .pick  (pick)
    );

    // Priority lane keeps winning until it has taken STARVE_LIMIT messages past a waiting lane.
    assign other_valid = |(req_valid & ~PRIO_MASK);
    assign prio_win    = (|(req_valid & PRIO_MASK)) && ((starve_cnt < 8'(STARVE_LIMIT)) || !other_valid);
    assign grant_ok    = prio_win || pick_found;
    assign arb_grant   = prio_win ? lane_id_t'(PRIO_LANE) : pick;

    always_comb begin
        g_valid = 1'b0;
        g_data  = 8'h00;
        g_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == lane_id_t'(i)) begin
                g_valid = req_valid[i];
                g_data  = req_data[i];
                g_last  = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_valid) state_next = ARB;
            ARB:     state_next = grant_ok ? LOAD : IDLE;
            LOAD: begin
                if (accept) begin
                    state_next = GUARD;
                end else if (expire) begin
                    state_next = IDLE;
                end
            end
            GUARD:   state_next = DRAIN;
            DRAIN:   if (tx_ready) state_next = last_q ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Stall cycles only count while uart_tx could have taken a byte.
    always_comb begin
        accept    = (state == LOAD) && tx_ready && g_valid && !reset;
        stall     = (state == LOAD) && tx_ready && !g_valid;
        expire    = stall && (to_cnt == TW'(TIMEOUT - 1));
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant_id == lane_id_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_tx    <= 8'h00;
            valid      <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
            msg_abort  <= 1'b0;
            starve_cnt <= '0;
            rr         <= RR_INIT;
            to_cnt     <= '0;
            last_q     <= 1'b0;
        end else begin
            valid     <= accept;
            msg_abort <= expire;
            if (state == ARB && grant_ok) begin
                grant_id <= arb_grant;
                busy     <= 1'b1;
                if (prio_win) begin
                    starve_cnt <= other_valid ? starve_cnt + 8'd1 : 8'd0;
                end else begin
                    starve_cnt <= '0;
                    rr         <= next_lane(pick, NUM_REQ, PRIO_LANE);
                end
            end
            if (accept) begin
                data_tx <= g_data;
                last_q  <= g_last;
                to_cnt  <= '0;
            end else if (expire) begin
                to_cnt <= '0;
                busy   <= 1'b0;
            end else if (stall) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (state == DRAIN && tx_ready && last_q) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: lanes are fed from message queues, a message-level
// arbitration model predicts the byte stream, and a monitor checks every strobe against it.
module tb_uart_tx_arbiter;

    localparam int N    = 2;
    localparam int PRIO = 0;
    localparam int SL   = 3;
    localparam int TMO  = 1023;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [7:0]        data_tx;
    logic              valid;
    logic              tx_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              msg_abort;

    typedef struct { logic [7:0] d; logic l; int gap; } byte_t;
    typedef struct { int lane; logic [7:0] d; } exp_t;

    byte_t lane_q[N][$];
    exp_t  exp_q[$];
    exp_t  e;
    int    n_cmp = 0, n_fail = 0;
    int    cyc = 0, strobes = 0, aborts = 0, last_valid_cyc = 0, last_abort_cyc = 0;
    int    accepts[N];
    bit    pend[N];
    int    gap_cnt[N];
    int    busy_cnt = 0, busy_len = 0;
    bit    rand_busy = 0, force_low = 0;
    int    m_starve = 0, m_rr = (PRIO + 1) % N;

    uart_tx_arbiter #(.NUM_REQ(N), .PRIO_LANE(PRIO), .STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .data_tx   (data_tx),
        .valid     (valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .msg_abort (msg_abort)
    );

    always #10 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Requester lanes and a uart_tx stand-in that drops tx_ready for busy_cnt cycles after each strobe.
    task automatic apply_stimulus();
        byte_t b;
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                pend[i] = 1'b0;
                if (lane_q[i].size() > 0) begin
                    b = lane_q[i].pop_front();
                    gap_cnt[i] = b.l ? 0 : b.gap;
                end
            end
            if (gap_cnt[i] > 0) begin
                gap_cnt[i]--;
                req_valid[i] = 1'b0;
            end else if (lane_q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i]  = lane_q[i][0].d;
                req_last[i]  = lane_q[i][0].l;
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = 8'h00;
                req_last[i]  = 1'b0;
            end
        end
        if (force_low) begin
            tx_ready = 1'b0;
        end else if (busy_cnt > 0) begin
            tx_ready = 1'b0;
            busy_cnt--;
        end else begin
            tx_ready = 1'b1;
        end
    endtask

    initial begin
        tx_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            accepts[i] = 0;
            pend[i]    = 1'b0;
            gap_cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            apply_stimulus();
        end
    end

    // Monitor: every accept and every strobe must match the head of the expected stream.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (req_ready != '0) begin
                    if (exp_q.size() == 0) begin
                        check_output("req_ready_unexpected", 32'(req_ready), 32'd0);
                    end else begin
                        check_output("req_ready_lane", 32'(req_ready), 32'd1 << exp_q[0].lane);
                        for (int i = 0; i < N; i++) begin
                            if (req_ready[i]) begin
                                pend[i] = 1'b1;
                                accepts[i]++;
                            end
                        end
                    end
                end
                if (valid) begin
                    strobes++;
                    last_valid_cyc = cyc;
                    busy_cnt = rand_busy ? int'($urandom_range(0, 6)) : busy_len;
                    if (exp_q.size() == 0) begin
                        check_output("valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("data_tx", 32'(data_tx), 32'(e.d));
                        check_output("grant_id", 32'(grant_id), 32'(e.lane));
                        check_output("busy_on_valid", 32'(busy), 32'd1);
                    end
                end
                if (msg_abort) begin
                    aborts++;
                    last_abort_cyc = cyc;
                end
            end
        end
    end

    // Message-level model: whole messages are scheduled from the lanes' pending queues.
    task automatic model_schedule();
        byte_t cq[N][$];
        byte_t b;
        int    lane;
        bit    other;
        for (int i = 0; i < N; i++) cq[i] = lane_q[i];
        forever begin
            other = 1'b0;
            for (int i = 0; i < N; i++) if (i != PRIO && cq[i].size() > 0) other = 1'b1;
            if (!other && cq[PRIO].size() == 0) break;
            if (cq[PRIO].size() > 0 && (m_starve < SL || !other)) begin
                lane = PRIO;
                m_starve = other ? m_starve + 1 : 0;
            end else begin
                lane = -1;
                for (int k = 0; k < N; k++) begin
                    if (lane < 0 && ((m_rr + k) % N) != PRIO && cq[(m_rr + k) % N].size() > 0) begin
                        lane = (m_rr + k) % N;
                    end
                end
                m_rr = (lane + 1) % N;
                if (m_rr == PRIO) m_rr = (m_rr + 1) % N;
                m_starve = 0;
            end
            do begin
                b = cq[lane].pop_front();
                exp_q.push_back('{lane: lane, d: b.d});
            end while (!b.l);
        end
    endtask

    task automatic push_byte(input int lane, input logic [7:0] d, input logic l, input int gap);
        lane_q[lane].push_back('{d: d, l: l, gap: gap});
    endtask

    task automatic push_exp(input int lane, input logic [7:0] d);
        exp_q.push_back('{lane: lane, d: d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            lane_q[i].delete();
            pend[i]    = 1'b0;
            gap_cnt[i] = 0;
        end
        exp_q.delete();
        busy_cnt  = 0;
        force_low = 1'b0;
        rand_busy = 1'b0;
        m_starve  = 0;
        m_rr      = (PRIO + 1) % N;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int  k;
        bit  pending;
        k = 0;
        forever begin
            pending = (exp_q.size() > 0) || (busy !== 1'b0);
            for (int i = 0; i < N; i++) if (lane_q[i].size() > 0) pending = 1'b1;
            if (!pending || k >= budget) break;
            @(negedge clk);
            k++;
        end
        check_output({name, "_completes"}, 32'(k < budget), 32'd1);
        check_output({name, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (strobes < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output({name, "_strobe_seen"}, 32'(strobes >= target), 32'd1);
    endtask

    initial begin
        int s0, a0, acc0, vcyc, k, nmsg, len;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_data_tx", 32'(data_tx), 32'd0);
        check_output("rst_valid", 32'(valid), 32'd0);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_grant_id", 32'(grant_id), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_msg_abort", 32'(msg_abort), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);

        // Three-byte command message on lane 0 with a slow uart_tx
        busy_len = 10;
        push_byte(0, 8'h46, 1'b0, 0);
        push_byte(0, 8'h32, 1'b0, 0);
        push_byte(0, 8'h0A, 1'b1, 0);
        model_schedule();
        s0 = strobes;
        wait_idle(400, "t1");
        check_output("t1_strobe_count", 32'(strobes - s0), 32'd3);

        // Lane 1 mid-message when lane 0 arrives: lane 1 finishes first
        busy_len = 2;
        push_byte(1, 8'hA1, 1'b0, 0);
        push_byte(1, 8'hA2, 1'b1, 0);
        push_exp(1, 8'hA1);
        push_exp(1, 8'hA2);
        k = 0;
        while (accepts[1] == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_output("t2_lane1_accepted", 32'(accepts[1] > 0), 32'd1);
        push_byte(0, 8'hB0, 1'b1, 0);
        push_exp(0, 8'hB0);
        wait_idle(400, "t2");

        // Both lanes continuously valid, one-byte messages: 0,0,0,1,0,0,0,1
        do_reset();
        busy_len = 1;
        for (int i = 0; i < 6; i++) push_byte(0, 8'h10 + 8'(i), 1'b1, 0);
        for (int i = 0; i < 2; i++) push_byte(1, 8'h20 + 8'(i), 1'b1, 0);
        push_exp(0, 8'h10); push_exp(0, 8'h11); push_exp(0, 8'h12); push_exp(1, 8'h20);
        push_exp(0, 8'h13); push_exp(0, 8'h14); push_exp(0, 8'h15); push_exp(1, 8'h21);
        wait_idle(600, "t3");

        // Randomized traffic against the message-level model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            rand_busy = 1'b1;
            for (int ln = 0; ln < N; ln++) begin
                nmsg = int'($urandom_range(1, 5));
                for (int m = 0; m < nmsg; m++) begin
                    len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) begin
                        push_byte(ln, 8'($urandom), 1'(b == len - 1), int'($urandom_range(0, 3)));
                    end
                end
            end
            model_schedule();
            wait_idle(3000, "rand");
        end

        // Lane 1 stalls after its first byte: timeout abort, then lane 0 served
        do_reset();
        busy_len = 3;
        push_byte(1, 8'h5A, 1'b0, 0);
        push_exp(1, 8'h5A);
        a0 = aborts;
        wait_strobes(strobes + 1, 200, "t4");
        vcyc = last_valid_cyc;
        push_byte(0, 8'hC0, 1'b0, 0);
        push_byte(0, 8'hC1, 1'b1, 0);
        push_exp(0, 8'hC0);
        push_exp(0, 8'hC1);
        k = 0;
        while (aborts == a0 && k < 1500) begin
            @(negedge clk);
            k++;
        end
        check_output("t4_abort_seen", 32'(aborts - a0), 32'd1);
        check_output("t4_abort_delay", 32'(last_abort_cyc - vcyc), 32'(busy_len + TMO + 2));
        wait_idle(400, "t4");
        check_output("t4_single_abort", 32'(aborts - a0), 32'd1);

        // Reset during DRAIN of a 4-byte message
        do_reset();
        busy_len = 5;
        for (int i = 0; i < 4; i++) push_byte(0, 8'h31 + 8'(i), 1'(i == 3), 0);
        model_schedule();
        s0 = strobes;
        wait_strobes(s0 + 2, 300, "t5");
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            lane_q[i].delete();
            pend[i] = 1'b0;
        end
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_output("t5_data_tx", 32'(data_tx), 32'd0);
        check_output("t5_valid", 32'(valid), 32'd0);
        check_output("t5_req_ready", 32'(req_ready), 32'd0);
        check_output("t5_grant_id", 32'(grant_id), 32'd0);
        check_output("t5_busy", 32'(busy), 32'd0);
        check_output("t5_msg_abort", 32'(msg_abort), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        s0 = strobes;
        repeat (50) @(negedge clk);
        check_output("t5_no_more_strobes", 32'(strobes - s0), 32'd0);

        // tx_ready held low: nothing moves and nothing times out
        do_reset();
        force_low = 1'b1;
        repeat (2) @(negedge clk);
        push_byte(0, 8'h77, 1'b1, 0);
        model_schedule();
        s0   = strobes;
        a0   = aborts;
        acc0 = accepts[0];
        repeat (2000) @(negedge clk);
        check_output("t6_no_valid", 32'(strobes - s0), 32'd0);
        check_output("t6_no_req_ready", 32'(accepts[0] - acc0), 32'd0);
        check_output("t6_no_abort", 32'(aborts - a0), 32'd0);
        force_low = 1'b0;
        wait_idle(200, "t6");
        check_output("t6_resumed", 32'(strobes - s0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
